// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared conv constants, FSM encodings and address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    localparam int IMG_W_DEF = 32;
    localparam int K_DEF     = 5;
    localparam int OUT_W_DEF = 28;

    localparam int ADDR_W  = 10;
    localparam int WADDR_W = 8;
    localparam int CNT_W   = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Row wrap jumps over the K-1 columns no window starts in.
    function automatic logic [ADDR_W-1:0] next_img_addr(
        input logic [ADDR_W-1:0] addr,
        input logic              col_wrap,
        input int                k
    );
        return col_wrap ? addr + ADDR_W'(k) : addr + ADDR_W'(1);
    endfunction

endpackage : conv_pkg
`default_nettype wire

// File: rtl/conv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : conv_sequencer_if
// Description : Control/address bundle between frame controller and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface conv_sequencer_if;
    import conv_pkg::*;

    logic                go;
    logic                abort;
    logic                ac_done;
    logic                start;
    logic [ADDR_W-1:0]   img_addr;
    logic [WADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]   pix_addr;
    logic                busy;
    logic                frame_done;

    modport master (
        output go, abort, ac_done,
        input  start, img_addr, w_addr, pix_addr, busy, frame_done
    );

    modport slave (
        input  go, abort, ac_done,
        output start, img_addr, w_addr, pix_addr, busy, frame_done
    );

endinterface : conv_sequencer_if
`default_nettype wire

// File: rtl/conv_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_pos_counter
// Description : Row/column position of the current output pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int OUT_W = OUT_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr_i,
    input  wire logic             adv_i,
    output logic [CNT_W-1:0]      row_o,
    output logic [CNT_W-1:0]      col_o,
    output logic                  col_wrap_o
);

    logic [CNT_W-1:0] row_q;
    logic [CNT_W-1:0] col_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            row_q <= '0;
            col_q <= '0;
        end else if (adv_i) begin
            if (col_wrap_o) begin
                col_q <= '0;
                row_q <= row_q + CNT_W'(1);
            end else begin
                col_q <= col_q + CNT_W'(1);
            end
        end
    end

    assign row_o      = row_q;
    assign col_o      = col_q;
    assign col_wrap_o = (col_q == CNT_W'(OUT_W - 1));

endmodule : conv_pos_counter
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_sequencer
// Description : Walks every KxK window of a frame, one start per output pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int                 IMG_W    = IMG_W_DEF,
    parameter int                 K        = K_DEF,
    parameter int                 OUT_W    = OUT_W_DEF,
    parameter logic [ADDR_W-1:0]  IMG_BASE = 10'h000,
    parameter logic [WADDR_W-1:0] W_BASE   = 8'h00
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv_sequencer_if.slave  bus
);

    generate
        if (OUT_W != IMG_W - K + 1) begin : g_param_check
            $error("conv_sequencer: OUT_W must equal IMG_W-K+1");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   img_addr_q, img_addr_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [WADDR_W-1:0]  w_addr_q;
    logic                start_q, busy_q, frame_done_q;
    logic                cnt_clr, cnt_adv;
    logic [CNT_W-1:0]    row, col;
    logic                col_wrap, last_win;

    conv_pos_counter #(.OUT_W(OUT_W)) u_pos (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .adv_i      (cnt_adv),
        .row_o      (row),
        .col_o      (col),
        .col_wrap_o (col_wrap)
    );

    assign last_win = col_wrap && (row == CNT_W'(OUT_W - 1));

    always_comb begin
        state_d    = state_q;
        img_addr_d = img_addr_q;
        pix_addr_d = pix_addr_q;
        cnt_clr    = 1'b0;
        cnt_adv    = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.go) begin
                    state_d    = ST_ISSUE;
                    img_addr_d = IMG_BASE;
                    pix_addr_d = '0;
                    cnt_clr    = 1'b1;
                end
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT: if (bus.ac_done) begin
                    if (last_win) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ISSUE;
                        cnt_adv    = 1'b1;
                        img_addr_d = next_img_addr(img_addr_q, col_wrap, K);
                        pix_addr_d = pix_addr_q + ADDR_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Flags are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            img_addr_q   <= IMG_BASE;
            pix_addr_q   <= '0;
            w_addr_q     <= W_BASE;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            img_addr_q   <= img_addr_d;
            pix_addr_q   <= pix_addr_d;
            w_addr_q     <= W_BASE;
            start_q      <= (state_d == ST_ISSUE);
            busy_q       <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
            frame_done_q <= (state_d == ST_DONE);
        end
    end

    assign bus.start      = start_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.img_addr   = img_addr_q;
    assign bus.pix_addr   = pix_addr_q;
    assign bus.w_addr     = w_addr_q;

endmodule : conv_sequencer
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_sequencer
// Description : Directed vector table plus frame-level sequences for conv_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   start_cnt = 0;
    int   fd_cnt = 0;

    conv_sequencer_if bus ();

    conv_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.start)      start_cnt++;
        if (bus.frame_done) fd_cnt++;
    end

    typedef struct {
        logic       rst, go, abort, ac_done;
        logic       start, busy, frame_done;
        logic [9:0] img, pix;
    } vec_t;

    vec_t tv[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_img(input int p);
        return 10'((p / 28) * 32 + (p % 28));
    endfunction

    task automatic do_reset();
        bus.go = 0; bus.abort = 0; bus.ac_done = 0;
        rst = 1; step(); rst = 0;
    endtask

    // Entered with start just sampled high for pixel p.
    task automatic serve(input int lat, input int p, input bit inject_go);
        chk("start_at_pixel", {63'd0, bus.start}, 64'd1);
        chk("addr_at_start", {44'd0, bus.img_addr, bus.pix_addr}, {44'd0, exp_img(p), 10'(p)});
        step();
        if (inject_go) bus.go = 1;
        for (int i = 1; i < lat; i++) step();
        bus.go = 0;
        chk("wait_hold", {42'd0, bus.start, bus.busy, bus.img_addr, bus.pix_addr},
            {42'd0, 1'b0, 1'b1, exp_img(p), 10'(p)});
        bus.ac_done = 1; step(); bus.ac_done = 0;
    endtask

    initial begin
        int s0, f0;
        bus.go = 0; bus.abort = 0; bus.ac_done = 0;

        //          rst go ab acd   st bz fd img    pix
        tv[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd0, 10'd0};
        tv[1]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd0, 10'd0};
        tv[2]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 10'd0, 10'd0};
        tv[3]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 10'd0, 10'd0};
        tv[4]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 10'd0, 10'd0};
        tv[5]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 10'd0, 10'd0};
        tv[6]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 10'd1, 10'd1};
        tv[7]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 10'd1, 10'd1};
        tv[8]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 10'd2, 10'd2};
        tv[9]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 10'd2, 10'd2};
        tv[10] = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0, 10'd0, 10'd0};
        tv[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 10'd0, 10'd0};
        tv[12] = '{1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 10'd0, 10'd0};

        step();
        for (int v = 0; v < 13; v++) begin
            rst = tv[v].rst; bus.go = tv[v].go; bus.abort = tv[v].abort; bus.ac_done = tv[v].ac_done;
            step();
            chk($sformatf("vector_%0d", v),
                {33'd0, bus.start, bus.busy, bus.frame_done, bus.img_addr, bus.pix_addr, bus.w_addr},
                {33'd0, tv[v].start, tv[v].busy, tv[v].frame_done, tv[v].img, tv[v].pix, 8'h00});
        end

        // Full frame with a 26-cycle address controller.
        do_reset();
        s0 = start_cnt; f0 = fd_cnt;
        bus.go = 1; step(); bus.go = 0;
        for (int p = 0; p < 784; p++) serve(26, p, 1'b0);
        chk("last_done_busy_start", {61'd0, bus.frame_done, bus.busy, bus.start}, 64'b100);
        step();
        chk("frame_done_one_cycle", {63'd0, bus.frame_done}, 64'd0);
        chk("final_addr_hold", {44'd0, bus.img_addr, bus.pix_addr}, {44'd0, 10'd891, 10'd783});
        for (int i = 0; i < 30; i++) step();
        chk("start_pulse_count", 64'(start_cnt - s0), 64'd784);
        chk("frame_done_count", 64'(fd_cnt - f0), 64'd1);

        // go during WAIT of pixel 5 is ignored.
        do_reset();
        bus.go = 1; step(); bus.go = 0;
        for (int p = 0; p < 8; p++) serve(3, p, p == 5);

        // abort coinciding with ac_done at pixel 100.
        do_reset();
        bus.go = 1; step(); bus.go = 0;
        for (int p = 0; p < 100; p++) serve(2, p, 1'b0);
        chk("abort_pixel_100", {44'd0, bus.img_addr, bus.pix_addr}, {44'd0, exp_img(100), 10'd100});
        step(); step();
        s0 = start_cnt; f0 = fd_cnt;
        bus.ac_done = 1; bus.abort = 1; step(); bus.ac_done = 0; bus.abort = 0;
        chk("abort_outputs", {61'd0, bus.start, bus.busy, bus.frame_done}, 64'd0);
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_pulses", 64'((start_cnt - s0) + (fd_cnt - f0)), 64'd0);
        bus.go = 1; step(); bus.go = 0;
        chk("restart_after_abort", {43'd0, bus.start, bus.img_addr, bus.pix_addr}, {43'd0, 1'b1, 10'd0, 10'd0});

        // rst during ISSUE, ac_done held high afterwards.
        do_reset();
        bus.go = 1; step(); bus.go = 0;
        bus.ac_done = 1; step(); bus.ac_done = 0;
        bus.ac_done = 1; step();
        chk("in_issue_before_rst", {63'd0, bus.start}, 64'd1);
        rst = 1; step(); rst = 0;
        chk("rst_in_issue", {33'd0, bus.start, bus.busy, bus.frame_done, bus.img_addr, bus.pix_addr, bus.w_addr}, 64'd0);
        for (int i = 0; i < 3; i++) step();
        chk("ac_done_ignored_idle", {61'd0, bus.start, bus.busy, bus.frame_done}, 64'd0);
        bus.ac_done = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_conv_sequencer
`default_nettype wire
